uart_mmio_bridge: RTL and testbench

- Memory-mapped I/O responder between the Riscv151 datapath (initiator) and the on-chip uart ready/valid ports.
- Decodes CPU loads and stores in the 0x8000_00xx I/O region.
- Buffers received bytes in a small FIFO and holds one transmit byte.
- Provides free-running cycle and retired-instruction counters for benchmarking.
- Read data returns with one-cycle latency, matching the BIOS/DMEM synchronous-read timing, so the writeback mux treats all sources uniformly.

---
 rtl/uart_mmio_bridge.sv | 142 ++++++++++++++
 tb/tb_uart_mmio_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_bridge.sv
// Memory-mapped responder linking the CPU load/store port to the uart ready/valid
// interfaces: RX FIFO, TX holding register, cycle and retired-instruction counters.
module uart_mmio_bridge #(
    parameter int unsigned RX_FIFO_DEPTH = 8,
    parameter logic [31:0] IO_BASE       = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic [3:0]  we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        inst_retired,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);

    localparam int unsigned AW = $clog2(RX_FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = RX_FIFO_DEPTH[AW:0];

    // Word offsets within the register block (addr[7:2]).
    typedef enum logic [5:0] {
        REG_CTRL = 6'h00,
        REG_RX   = 6'h01,
        REG_TX   = 6'h02,
        REG_CYC  = 6'h04,
        REG_INST = 6'h05,
        REG_CLR  = 6'h06
    } reg_e;

    logic        hit;
    logic [5:0]  word;
    logic        store;
    logic        rx_read;
    logic        tx_store;
    logic        cnt_clear;

    logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] rd_val;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign hit       = (addr[31:8] == IO_BASE[31:8]);
    assign word      = addr[7:2];
    assign store     = |we;
    assign rx_read   = re && hit && (word == REG_RX);
    assign tx_store  = store && hit && (word == REG_TX);
    assign cnt_clear = store && hit && (word == REG_CLR);

    assign fifo_full     = (count == FULL_COUNT);
    assign fifo_empty    = (count == '0);
    assign uart_rx_ready = !fifo_full;
    assign push          = uart_rx_valid && !fifo_full;
    assign pop           = rx_read && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A store landing in the handshake cycle sees the register still full and is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end else if (!uart_tx_valid && tx_store) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'd0, inst_retired};
        end
    end

    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (word)
                REG_CTRL: rd_val = {30'd0, !fifo_empty, !uart_tx_valid};
                REG_RX:   rd_val = fifo_empty ? 32'd0 : {24'd0, fifo_mem[rd_ptr]};
                REG_CYC:  rd_val = cycle_cnt;
                REG_INST: rd_val = inst_cnt;
                default:  rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Scoreboard bench for uart_mmio_bridge: a queue-based reference model predicts every
// registered read and the uart-side outputs; a negedge monitor compares them.
module tb_uart_mmio_bridge;

    localparam int          DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = '0;
    logic        re = 1'b0;
    logic [3:0]  we = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        inst_retired = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_mmio_bridge #(
        .RX_FIFO_DEPTH(DEPTH),
        .IO_BASE(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .re(re),
        .we(we),
        .wdata(wdata),
        .rdata(rdata),
        .inst_retired(inst_retired),
        .uart_tx_data(uart_tx_data),
        .uart_tx_valid(uart_tx_valid),
        .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data),
        .uart_rx_valid(uart_rx_valid),
        .uart_rx_ready(uart_rx_ready)
    );

    // Reference state: FIFO as a queue, TX as a pending flag, counters as plain integers.
    logic [7:0]  m_rxq[$];
    bit          m_tx_pend = 1'b0;
    logic [7:0]  m_tx_data = '0;
    logic [31:0] m_cyc = '0;
    logic [31:0] m_inst = '0;
    logic [31:0] exp_q[$];
    bit          rd_pending = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] rv;
        logic [5:0]  w;
        bit          h;
        bit          st;
        bit          rdy;
        if (rst) begin
            m_rxq.delete();
            m_tx_pend = 1'b0;
            m_tx_data = '0;
            m_cyc     = '0;
            m_inst    = '0;
            exp_q.push_back(32'd0);
        end else begin
            h   = (addr[31:8] == BASE[31:8]);
            w   = addr[7:2];
            st  = (we != 4'd0);
            rdy = (m_rxq.size() < DEPTH);
            rv  = '0;
            if (h) begin
                case (w)
                    6'd0: rv = {30'd0, m_rxq.size() != 0, !m_tx_pend};
                    6'd1: rv = (m_rxq.size() != 0) ? {24'd0, m_rxq[0]} : 32'd0;
                    6'd4: rv = m_cyc;
                    6'd5: rv = m_inst;
                    default: rv = '0;
                endcase
            end
            if (re) exp_q.push_back(rv);
            if (re && h && w == 6'd1 && m_rxq.size() != 0) void'(m_rxq.pop_front());
            if (uart_rx_valid && rdy) m_rxq.push_back(uart_rx_data);
            if (m_tx_pend && uart_tx_ready) begin
                m_tx_pend = 1'b0;
            end else if (!m_tx_pend && st && h && w == 6'd2) begin
                m_tx_pend = 1'b1;
                m_tx_data = wdata[7:0];
            end
            if (st && h && w == 6'd6) begin
                m_cyc  = '0;
                m_inst = '0;
            end else begin
                m_cyc  = m_cyc + 32'd1;
                m_inst = m_inst + {31'd0, inst_retired};
            end
        end
    end

    always @(posedge clk) rd_pending <= rst || re;

    always @(negedge clk) begin : monitor
        chk("tx_valid", {31'd0, uart_tx_valid}, {31'd0, m_tx_pend});
        chk("tx_data", {24'd0, uart_tx_data}, {24'd0, m_tx_data});
        chk("rx_ready", {31'd0, uart_rx_ready}, {31'd0, m_rxq.size() < DEPTH});
        if (rd_pending) begin
            if (exp_q.size() == 0) begin
                chk("rdata_unexpected", rdata, 32'hDEAD_BEEF);
            end else begin
                chk("rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic [31:0] a, input bit r, input logic [3:0] w, input logic [31:0] d);
        addr  = a;
        re    = r;
        we    = w;
        wdata = d;
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] off);
        cyc(BASE + {24'd0, off}, 1'b1, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        cyc(BASE + {24'd0, off}, 1'b0, 4'hF, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(32'd0, 1'b0, 4'd0, 32'd0);
    endtask

    initial begin : timeout
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Post-reset control read
        rd(8'h00);
        idle(1);

        // TX hold with a dropped second store
        uart_tx_ready = 1'b0;
        wr(8'h08, 32'h0000_0041);
        rd(8'h00);
        wr(8'h08, 32'h0000_0055);
        idle(3);
        uart_tx_ready = 1'b1;
        idle(1);
        uart_tx_ready = 1'b0;
        rd(8'h00);
        idle(1);

        // Fill the FIFO, offer a ninth byte, then drain past empty
        for (int i = 1; i <= 8; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(i);
            idle(1);
        end
        uart_rx_data = 8'h09;
        idle(2);
        uart_rx_valid = 1'b0;
        rd(8'h00);
        for (int i = 0; i < 9; i++) rd(8'h04);
        rd(8'h00);

        // Simultaneous push and pop with three bytes held, then with the FIFO empty
        for (int i = 0; i < 3; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'hA0 + 8'(i);
            idle(1);
        end
        uart_rx_data = 8'hB0;
        rd(8'h04);
        uart_rx_valid = 1'b0;
        for (int i = 0; i < 4; i++) rd(8'h04);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hC5;
        rd(8'h04);
        uart_rx_valid = 1'b0;
        rd(8'h04);
        rd(8'h00);

        // Counters with inst_retired on alternate cycles, clear, and read-during-clear
        wr(8'h18, 32'd0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 0);
            idle(1);
        end
        inst_retired = 1'b0;
        rd(8'h10);
        rd(8'h14);
        cyc(BASE + 32'h18, 1'b1, 4'h1, 32'd0);
        rd(8'h10);
        rd(8'h14);

        // Unmapped and out-of-region accesses
        rd(8'h0C);
        cyc(32'h8000_0110, 1'b1, 4'd0, 32'd0);
        cyc(32'h8000_0108, 1'b0, 4'hF, 32'h0000_0077);
        rd(8'h00);

        // Reset with a TX byte pending and the FIFO non-empty
        wr(8'h08, 32'h0000_005A);
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h33;
        idle(2);
        uart_rx_valid = 1'b0;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rd(8'h00);
        rd(8'h10);
        rd(8'h14);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            uart_rx_valid = ($urandom_range(0, 2) != 0);
            uart_rx_data  = 8'($urandom);
            uart_tx_ready = ($urandom_range(0, 3) == 0);
            inst_retired  = $urandom_range(0, 1) == 1;
            rst           = ($urandom_range(0, 299) == 0);
            a = BASE + {24'd0, 3'($urandom_range(0, 7)), 2'b00} * 32'd1 + {30'd0, 2'($urandom)};
            a = BASE + {24'd0, 1'b0, 3'($urandom_range(0, 7)), 2'b00, 2'($urandom)};
            if ($urandom_range(0, 9) == 0) a = $urandom;
            cyc(a, $urandom_range(0, 1) == 1,
                ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                $urandom);
        end
        rst           = 1'b0;
        uart_rx_valid = 1'b0;
        inst_retired  = 1'b0;
        idle(3);
        chk("scoreboard_drain", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
